// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// micro_sequencer : per-opcode phase sequencer feeding the register selector
// Revision        : 1.0
// ============================================================================
module micro_sequencer #(
    parameter int OPW = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           inst_valid,
    output logic           inst_ready,
    input  logic [OPW-1:0] opcode,
    input  logic           stall,
    output logic [3:0]     phase,
    output logic [7:0]     phase_strobe,
    output logic           clock_3,
    output logic           clock_5,
    output logic           clock_7,
    output logic [3:0]     select_1,
    output logic [3:0]     select_2,
    output logic [3:0]     select_3,
    output logic           done,
    output logic           illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [OPW-1:0] c_op_push_ebp = OPW'(8'h55);
    localparam logic [OPW-1:0] c_op_push_eax = OPW'(8'h50);
    localparam logic [OPW-1:0] c_op_pop_ebp  = OPW'(8'h5D);
    localparam logic [OPW-1:0] c_op_mov      = OPW'(8'h89);
    localparam logic [OPW-1:0] c_op_call     = OPW'(8'hE8);
    localparam logic [OPW-1:0] c_op_ret      = OPW'(8'hC3);

    state_t     state_q,   state_d;
    logic [3:0] phase_q,   phase_d;
    logic [3:0] len_q,     len_d;
    logic [3:0] sel1_q,    sel1_d;
    logic [3:0] sel2_q,    sel2_d;
    logic [3:0] sel3_q,    sel3_d;
    logic       illegal_q, illegal_d;

    logic [3:0] dec_sel1;
    logic [3:0] dec_sel2;
    logic [3:0] dec_sel3;
    logic [3:0] dec_len;
    logic       dec_illegal;

    always_comb begin
        dec_sel1    = 4'd0;
        dec_sel2    = 4'd0;
        dec_sel3    = 4'd0;
        dec_len     = 4'd2;
        dec_illegal = 1'b0;
        case (opcode)
            c_op_push_ebp: begin dec_sel1 = 4'd5; dec_sel2 = 4'd2; dec_sel3 = 4'd0; dec_len = 4'd6; end
            c_op_push_eax: begin dec_sel1 = 4'd6; dec_sel2 = 4'd2; dec_sel3 = 4'd0; dec_len = 4'd6; end
            c_op_pop_ebp:  begin dec_sel1 = 4'd4; dec_sel2 = 4'd2; dec_sel3 = 4'd0; dec_len = 4'd6; end
            c_op_mov:      begin dec_sel1 = 4'd2; dec_sel2 = 4'd0; dec_sel3 = 4'd0; dec_len = 4'd4; end
            c_op_call:     begin dec_sel1 = 4'd3; dec_sel2 = 4'd3; dec_sel3 = 4'd1; dec_len = 4'd8; end
            c_op_ret:      begin dec_sel1 = 4'd0; dec_sel2 = 4'd5; dec_sel3 = 4'd2; dec_len = 4'd8; end
            default:       dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        len_d     = len_q;
        sel1_d    = sel1_q;
        sel2_d    = sel2_q;
        sel3_d    = sel3_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid) begin
                    state_d   = ST_RUN;
                    phase_d   = 4'd1;
                    len_d     = dec_len;
                    sel1_d    = dec_sel1;
                    sel2_d    = dec_sel2;
                    sel3_d    = dec_sel3;
                    illegal_d = dec_illegal;
                end
            end
            ST_RUN: begin
                // A stalled cycle freezes everything so the pending strobe is replayed later
                if (!stall) begin
                    if (phase_q == len_q) begin
                        state_d = ST_DONE;
                        phase_d = 4'd0;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                sel1_d    = 4'd0;
                sel2_d    = 4'd0;
                sel3_d    = 4'd0;
                illegal_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                phase_d   = 4'd0;
                sel1_d    = 4'd0;
                sel2_d    = 4'd0;
                sel3_d    = 4'd0;
                illegal_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= 4'd0;
            len_q     <= 4'd0;
            sel1_q    <= 4'd0;
            sel2_q    <= 4'd0;
            sel3_q    <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            len_q     <= len_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
            sel3_q    <= sel3_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        phase_strobe = 8'd0;
        if ((state_q == ST_RUN) && !stall) begin
            for (int k = 0; k < 8; k++) begin
                phase_strobe[k] = (phase_q == 4'(k + 1));
            end
        end
    end

    assign inst_ready = (state_q == ST_IDLE);
    assign phase      = phase_q;
    assign clock_3    = phase_strobe[2];
    assign clock_5    = phase_strobe[4];
    assign clock_7    = phase_strobe[6];
    assign select_1   = sel1_q;
    assign select_2   = sel2_q;
    assign select_3   = sel3_q;
    assign done       = (state_q == ST_DONE);
    assign illegal    = (state_q == ST_DONE) && illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// tb_micro_sequencer : directed scoreboard bench for micro_sequencer
// Revision           : 1.0
// ============================================================================
module tb_micro_sequencer;

    logic       clock;
    logic       reset;
    logic       inst_valid;
    logic       inst_ready;
    logic [7:0] opcode;
    logic       stall;
    logic [3:0] phase;
    logic [7:0] phase_strobe;
    logic       clock_3;
    logic       clock_5;
    logic       clock_7;
    logic [3:0] select_1;
    logic [3:0] select_2;
    logic [3:0] select_3;
    logic       done;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    micro_sequencer #(.OPW(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .opcode       (opcode),
        .stall        (stall),
        .phase        (phase),
        .phase_strobe (phase_strobe),
        .clock_3      (clock_3),
        .clock_5      (clock_5),
        .clock_7      (clock_7),
        .select_1     (select_1),
        .select_2     (select_2),
        .select_3     (select_3),
        .done         (done),
        .illegal      (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [29:0] pack(input logic rdy, input logic [3:0] ph,
                                         input logic [7:0] stb, input logic [3:0] s1,
                                         input logic [3:0] s2, input logic [3:0] s3,
                                         input logic dn, input logic il);
        return {rdy, ph, stb, stb[2], stb[4], stb[6], s1, s2, s3, dn, il};
    endfunction

    function automatic logic [29:0] observed();
        return {inst_ready, phase, phase_strobe, clock_3, clock_5, clock_7,
                select_1, select_2, select_3, done, illegal};
    endfunction

    // Reference opcode table: sel1/sel2/sel3/len/illegal
    task automatic lookup(input logic [7:0] op, output logic [3:0] s1, output logic [3:0] s2,
                          output logic [3:0] s3, output logic [3:0] len, output logic ill);
        ill = 1'b0;
        case (op)
            8'h55:   begin s1 = 4'd5; s2 = 4'd2; s3 = 4'd0; len = 4'd6; end
            8'h50:   begin s1 = 4'd6; s2 = 4'd2; s3 = 4'd0; len = 4'd6; end
            8'h5D:   begin s1 = 4'd4; s2 = 4'd2; s3 = 4'd0; len = 4'd6; end
            8'h89:   begin s1 = 4'd2; s2 = 4'd0; s3 = 4'd0; len = 4'd4; end
            8'hE8:   begin s1 = 4'd3; s2 = 4'd3; s3 = 4'd1; len = 4'd8; end
            8'hC3:   begin s1 = 4'd0; s2 = 4'd5; s3 = 4'd2; len = 4'd8; end
            default: begin s1 = 4'd0; s2 = 4'd0; s3 = 4'd0; len = 4'd2; ill = 1'b1; end
        endcase
    endtask

    task automatic push(input string tag, input logic [29:0] v);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clock);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed=%h expected=<entry>", observed());
        end else begin
            e = sb.pop_front();
            assert (observed() === e.v) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, observed(), e.v);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            push($sformatf("%s idle%0d", name, i), pack(1'b1, 4'd0, 8'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
            step();
        end
    endtask

    // One instruction: accept cycle, RUN cycles (stall_map bit c = stall in cycle T+c), DONE.
    task automatic issue(input string name, input logic [7:0] op, input logic [15:0] stall_map,
                         input int abort_at, input logic acc_stall,
                         input logic nxt_valid, input logic [7:0] nxt_op);
        logic [3:0] s1, s2, s3, len, ph;
        logic       ill, st;
        logic [7:0] stb;
        lookup(op, s1, s2, s3, len, ill);
        inst_valid = 1'b1;
        opcode     = op;
        stall      = acc_stall;
        push({name, " accept"}, pack(1'b1, 4'd0, 8'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        step();
        inst_valid = nxt_valid;
        opcode     = nxt_op;
        ph = 4'd1;
        for (int c = 1; c < 40; c++) begin
            st    = stall_map[c];
            stall = st;
            stb   = st ? 8'd0 : (8'd1 << (ph - 4'd1));
            if (c == abort_at) reset = 1'b1;
            push($sformatf("%s c%0d", name, c), pack(1'b0, ph, stb, s1, s2, s3, 1'b0, 1'b0));
            step();
            if (c == abort_at) begin
                reset      = 1'b0;
                stall      = 1'b0;
                inst_valid = 1'b0;
                return;
            end
            if (!st && ph == len) break;
            if (!st) ph = ph + 4'd1;
        end
        stall = 1'b1;
        push({name, " done"}, pack(1'b0, 4'd0, 8'd0, s1, s2, s3, 1'b1, ill));
        step();
        stall = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        inst_valid = 1'b0;
        opcode     = 8'h00;
        stall      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle_check("reset", 2);

        issue("op55", 8'h55, 16'h0000, 0, 1'b0, 1'b0, 8'hA5);
        idle_check("op55_ready", 1);

        issue("opC3", 8'hC3, 16'h0000, 0, 1'b0, 1'b0, 8'h00);
        idle_check("opC3_ready", 1);

        issue("opE8_stall", 8'hE8, 16'h0018, 0, 1'b0, 1'b0, 8'h55);
        idle_check("opE8_ready", 1);

        issue("opFF", 8'hFF, 16'h0000, 0, 1'b1, 1'b0, 8'h55);
        idle_check("opFF_ready", 1);

        issue("op89_abort", 8'h89, 16'h0000, 4, 1'b0, 1'b0, 8'h89);
        idle_check("op89_after_reset", 6);

        issue("op50_b2b", 8'h50, 16'h0000, 0, 1'b0, 1'b1, 8'h5D);
        issue("op5D_b2b", 8'h5D, 16'h0000, 0, 1'b0, 1'b0, 8'h00);
        inst_valid = 1'b0;
        idle_check("op5D_ready", 2);

        issue("opE8_laststall", 8'hE8, 16'h0100, 0, 1'b0, 1'b0, 8'h00);
        idle_check("final", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
